shadow_reg_restore_unit: RTL and testbench

//  Restores one saved register frame from the shadow stack into the integer regfile on

---
 rtl/shadow_reg_restore_unit.sv | 148 ++++++++++++++
 tb/tb_shadow_reg_restore_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shadow_reg_restore_unit.sv
// Shadow register frame restore: reloads mepc and x1..x31 from the shadow
// stack on MRET, one dcache load at a time, through a dedicated rf write port.
module shadow_reg_restore_unit #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 5,
  parameter int FRAME_WORDS = 33
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  restore_i,
  input  logic [DATA_WIDTH-1:0] frame_base_i,
  input  logic [4:0]            save_level_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  level_dec_o,
  output logic [DATA_WIDTH-1:0] mepc_o,
  output logic                  mepc_valid_o,
  output logic                  mem_req_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o
);

  localparam int IW    = $clog2(FRAME_WORDS + 1);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BSH   = $clog2(BYTES);

  localparam logic [IW-1:0] LAST = IW'(FRAME_WORDS);
  localparam logic [DATA_WIDTH-1:0] SP_OFF =
    DATA_WIDTH'(FRAME_WORDS * BYTES);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, WR_SP, DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d, idx_nxt;
  logic [DATA_WIDTH-1:0]   base_q, base_d;
  logic [DATA_WIDTH-1:0]   mepc_q, mepc_d;
  logic                    mepc_vld_q, mepc_vld_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    done_q, done_d;

  // mcause (w1) is never reloaded and x2 (w3) comes from the frame base
  always_comb begin
    idx_nxt = idx_q + IW'(1);
    if (idx_q == IW'(0)) begin
      idx_nxt = IW'(2);
    end else if (idx_q == IW'(2)) begin
      idx_nxt = IW'(4);
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    base_d     = base_q;
    mepc_d     = mepc_q;
    mepc_vld_d = mepc_vld_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (restore_i && save_level_i != '0) begin
          base_d     = frame_base_i;
          idx_d      = '0;
          mepc_vld_d = 1'b0;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          if (idx_q == IW'(0)) begin
            mepc_d     = mem_rdata_i;
            mepc_vld_d = 1'b1;
          end
          if (idx_q >= IW'(2)) begin
            we_d    = 1'b1;
            waddr_d = ADDR_WIDTH'(idx_q - IW'(1));
            wdata_d = mem_rdata_i;
          end
          idx_d   = idx_nxt;
          state_d = (idx_nxt < LAST) ? REQ : WR_SP;
        end
      end
      WR_SP: begin
        we_d    = 1'b1;
        waddr_d = ADDR_WIDTH'(2);
        wdata_d = base_q + SP_OFF;
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      base_q     <= '0;
      mepc_q     <= '0;
      mepc_vld_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      base_q     <= base_d;
      mepc_q     <= mepc_d;
      mepc_vld_q <= mepc_vld_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign level_dec_o  = done_q;
  assign mepc_o       = mepc_q;
  assign mepc_valid_o = mepc_vld_q;
  assign mem_req_o    = (state_q == REQ);
  assign mem_addr_o   = base_q + (DATA_WIDTH'(idx_q) << BSH);
  assign rf_we_o      = we_q;
  assign rf_waddr_o   = waddr_q;
  assign rf_wdata_o   = wdata_q;

endmodule

// File: tb/tb_shadow_reg_restore_unit.sv
// Bench for shadow_reg_restore_unit: memory responder, rf write monitor
// and a frame-level reference model.
module tb_shadow_reg_restore_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        restore_i;
  logic [63:0] frame_base_i;
  logic [4:0]  save_level_i;
  logic        busy_o, done_o, level_dec_o;
  logic [63:0] mepc_o;
  logic        mepc_valid_o;
  logic        mem_req_o;
  logic [63:0] mem_addr_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [63:0] mem_rdata_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [63:0] rf_wdata_o;

  shadow_reg_restore_unit dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .restore_i(restore_i),
    .frame_base_i(frame_base_i), .save_level_i(save_level_i),
    .busy_o(busy_o), .done_o(done_o), .level_dec_o(level_dec_o),
    .mepc_o(mepc_o), .mepc_valid_o(mepc_valid_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .rf_we_o(rf_we_o),
    .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  int ncmp = 0;
  int nfail = 0;

  logic [63:0] words [0:32];
  logic [63:0] cur_base;
  int          gmax, rmax;
  bit          rnd, spur;
  logic        rsp_gnt, rsp_rv, man_rv;
  logic [63:0] rsp_rdata, man_rdata;
  int          rv_cnt, stab_err, done_cnt, dc0;
  logic [4:0]  wa[$];
  logic [63:0] wd[$];
  logic [63:0] gaddr[$];

  assign mem_gnt_i    = rsp_gnt;
  assign mem_rvalid_i = rsp_rv | man_rv;
  assign mem_rdata_i  = man_rv ? man_rdata : rsp_rdata;

  // memory: one outstanding load, configurable gnt / rvalid delays
  initial begin
    bit          pend;
    int          wcnt, gd, rcnt;
    logic [63:0] paddr, prev;
    int          k;
    rsp_gnt = 0; rsp_rv = 0; rsp_rdata = '0;
    rv_cnt = 0; stab_err = 0;
    pend = 0; wcnt = 0; gd = 0; rcnt = 0; paddr = '0; prev = '0;
    forever begin
      @(posedge clk_i); #1;
      rsp_gnt = 0; rsp_rv = 0;
      if (!rst_ni) begin
        pend = 0; wcnt = 0;
      end else if (pend) begin
        if (rcnt == 0) begin
          k = int'((paddr - cur_base) >> 3);
          rsp_rv = 1;
          rsp_rdata = (k >= 0 && k <= 32) ? words[k] : 64'hBAD;
          pend = 0;
          rv_cnt++;
        end else begin
          rcnt--;
        end
      end else if (mem_req_o) begin
        if (wcnt == 0) gd = rnd ? int'($urandom_range(gmax, 0)) : gmax;
        if (wcnt > 0 && mem_addr_o !== prev) stab_err++;
        prev = mem_addr_o;
        if (wcnt == gd) begin
          rsp_gnt = 1;
          gaddr.push_back(mem_addr_o);
          paddr = mem_addr_o;
          rcnt = rnd ? int'($urandom_range(rmax, 0)) : rmax;
          pend = 1;
          wcnt = 0;
        end else begin
          wcnt++;
          if (spur) begin
            rsp_rv = 1;
            rsp_rdata = 64'hDEAD_BEEF_0000_0000;
          end
        end
      end
    end
  end

  initial begin
    done_cnt = 0;
    forever begin
      @(posedge clk_i); #1;
      if (rf_we_o) begin
        wa.push_back(rf_waddr_o);
        wd.push_back(rf_wdata_o);
      end
      if (done_o) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic prep(input logic [63:0] base, input bit pattern);
    for (int k = 0; k < 33; k++)
      words[k] = pattern ? 64'h100 + 64'(k) : {$urandom, $urandom};
    cur_base = base;
    frame_base_i = base;
    wa.delete(); wd.delete(); gaddr.delete();
    dc0 = done_cnt;
  endtask

  task automatic kick(input logic [4:0] lvl);
    save_level_i = lvl;
    restore_i = 1;
    @(posedge clk_i); #2;
    restore_i = 0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 2000) begin
      @(posedge clk_i); #2;
      cyc++;
      if (done_o) break;
    end
    check("done_seen", done_o, 1);
    check("level_dec", level_dec_o, done_o);
  endtask

  // frame model: loads w0,w2,w4..w32; x(k-1)<=w[k]; x2<=base+33*8
  task automatic verify(input string tg, input logic [63:0] base);
    logic [4:0]  ea[$];
    logic [63:0] ed[$];
    logic [63:0] eg[$];
    repeat (2) @(posedge clk_i);
    #2;
    for (int k = 0; k <= 32; k++)
      if (k != 1 && k != 3) eg.push_back(base + 64'(8 * k));
    for (int r = 1; r <= 31; r++)
      if (r != 2) begin
        ea.push_back(5'(r));
        ed.push_back(words[r + 1]);
      end
    ea.push_back(5'd2);
    ed.push_back(base + 64'(33 * 8));
    check({tg, "_mepc"}, mepc_o, words[0]);
    check({tg, "_mepc_vld"}, mepc_valid_o, 1);
    check({tg, "_nwr"}, 64'(wa.size()), 64'(ea.size()));
    check({tg, "_nld"}, 64'(gaddr.size()), 64'(eg.size()));
    for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
      check($sformatf("%s_wa%0d", tg, i), 64'(wa[i]), 64'(ea[i]));
      check($sformatf("%s_wd%0d", tg, i), wd[i], ed[i]);
    end
    for (int i = 0; i < eg.size() && i < gaddr.size(); i++)
      check($sformatf("%s_ld%0d", tg, i), gaddr[i], eg[i]);
    check({tg, "_ndone"}, 64'(done_cnt - dc0), 1);
    check({tg, "_busy"}, busy_o, 0);
  endtask

  initial begin
    int cyc;
    int r0;
    logic [63:0] b;
    rst_ni = 0; restore_i = 0; frame_base_i = '0; save_level_i = '0;
    man_rv = 0; man_rdata = '0; gmax = 0; rmax = 0; rnd = 0; spur = 0;
    cur_base = '0;
    repeat (3) @(posedge clk_i);
    #2;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_req", mem_req_o, 0);
    check("rst_we", rf_we_o, 0);
    check("rst_mepc", mepc_o, 0);
    check("rst_mvld", mepc_valid_o, 0);
    rst_ni = 1;
    @(posedge clk_i); #2;

    // T1 zero-wait
    prep(64'h8000_1000, 1);
    kick(5'd1);
    wait_done(cyc);
    check("t1_cycles", 64'(cyc), 64);
    verify("t1", 64'h8000_1000);
    check("t1_x1", wd[0], 64'h102);
    check("t1_x2", wd[wd.size() - 1], 64'h8000_1108);

    // T6a spurious rvalid in IDLE
    wa.delete();
    man_rdata = 64'h1234; man_rv = 1;
    @(posedge clk_i); #2;
    man_rv = 0;
    repeat (3) @(posedge clk_i);
    #2;
    check("t6_idle_nwr", 64'(wa.size()), 0);

    // T2 gnt delayed 3
    prep(64'h8000_1000, 1);
    gmax = 3;
    kick(5'd1);
    check("t2_mvld_clr", mepc_valid_o, 0);
    wait_done(cyc);
    check("t2_cycles", 64'(cyc), 157);
    check("t2_stable", 64'(stab_err), 0);
    verify("t2", 64'h8000_1000);
    gmax = 0;

    // T3 level 0 and restore while busy
    dc0 = done_cnt;
    kick(5'd0);
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_req_o || busy_o) cyc++;
      @(posedge clk_i); #2;
    end
    check("t3_lvl0_idle", 64'(cyc), 0);
    check("t3_lvl0_done", 64'(done_cnt - dc0), 0);
    prep(64'h0000_4000, 0);
    kick(5'd3);
    repeat (10) @(posedge clk_i);
    #2;
    kick(5'd3);
    wait_done(cyc);
    verify("t3", 64'h0000_4000);

    // T4 address wrap
    b = 64'hFFFF_FFFF_FFFF_FFF0;
    prep(b, 0);
    kick(5'd2);
    wait_done(cyc);
    verify("t4", b);
    check("t4_w2addr", gaddr[1], 64'h0);
    check("t4_x2", wd[wd.size() - 1], 64'hF8);

    // T5 reset after 10th rvalid
    prep(64'h2000, 0);
    r0 = rv_cnt;
    kick(5'd1);
    cyc = 0;
    while (rv_cnt - r0 < 10 && cyc < 500) begin
      @(posedge clk_i); #2;
      cyc++;
    end
    check("t5_rv10", 64'(rv_cnt - r0), 10);
    @(posedge clk_i); #2;
    rst_ni = 0;
    #1;
    check("t5_busy", busy_o, 0);
    check("t5_req", mem_req_o, 0);
    check("t5_addr", mem_addr_o, 0);
    check("t5_we", rf_we_o, 0);
    check("t5_wa", 64'(rf_waddr_o), 0);
    check("t5_wd", rf_wdata_o, 0);
    check("t5_mepc", mepc_o, 0);
    check("t5_mvld", mepc_valid_o, 0);
    check("t5_done", done_o, 0);
    repeat (2) @(posedge clk_i);
    #2;
    rst_ni = 1;
    wa.delete(); wd.delete();
    man_rdata = 64'h5555; man_rv = 1;
    @(posedge clk_i); #2;
    man_rv = 0;
    repeat (3) @(posedge clk_i);
    #2;
    check("t5_late_rv", 64'(wa.size()), 0);
    prep(64'h3000, 0);
    kick(5'd1);
    wait_done(cyc);
    verify("t5", 64'h3000);

    // T6b spurious rvalid while in REQ
    prep(64'h6000, 0);
    gmax = 3; spur = 1;
    kick(5'd4);
    wait_done(cyc);
    verify("t6", 64'h6000);
    gmax = 0; spur = 0;

    // randomized frames and handshake delays
    rnd = 1;
    for (int it = 0; it < 6; it++) begin
      b = {$urandom, $urandom};
      b[2:0] = '0;
      gmax = int'($urandom_range(3, 0));
      rmax = int'($urandom_range(3, 0));
      prep(b, 0);
      kick(5'($urandom_range(31, 1)));
      wait_done(cyc);
      verify($sformatf("rnd%0d", it), b);
    end
    check("rnd_stable", 64'(stab_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
